writeback_unit: RTL and testbench

Writeback stage of the 8-bit CPU datapath. It accepts results from the execute stage through a valid/ready handshake and buffers them in a 2-entry queue. It commits them into an 8-entry × 8-bit register file and serves the two combinational operand read ports that feed the execute stage's `read_data1`/`read_data2` inputs. A commit trace and a commit counter are exported for debug and verification.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/wb_queue.sv | 68 ++++++
 rtl/writeback_unit.sv | 93 +++++++++
 tb/tb_writeback_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the 8-bit CPU datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int NREGS = 8;

    typedef logic [2:0] reg_addr_t;
    typedef logic [7:0] word_t;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
// Module   : wb_queue
// Brief    : 2-entry result FIFO between execute and writeback commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam logic [1:0] C_FULL_COUNT = 2'(DEPTH);

    wb_entry_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign full  = (r_count == C_FULL_COUNT);
    assign empty = (r_count == 2'd0);
    assign head  = r_mem[r_rd_ptr];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module   : writeback_unit
// Brief    : Writeback stage: result queue, 8x8 register file, commit trace.
//            Optional read bypass from the committing head: WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [2:0]  res_addr,
    input  logic [7:0]  res_data,
    input  logic        stall,
    input  logic [2:0]  rd_addr1,
    input  logic [2:0]  rd_addr2,
    output logic [7:0]  read_data1,
    output logic [7:0]  read_data2,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic [15:0] commit_count
);

    word_t      r_regs [NREGS];
    wb_entry_t  w_head;
    wb_entry_t  w_push_entry;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;

    assign res_ready    = !w_full;
    assign w_push       = res_valid && !w_full;
    assign w_pop        = !w_empty && !stall;
    assign w_push_entry = '{addr: res_addr, data: res_data};

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            commit_count <= '0;
        end else begin
            wb_valid <= w_pop;
            if (w_pop) begin
                wb_addr      <= w_head.addr;
                wb_data      <= w_head.data;
                commit_count <= commit_count + 16'd1;
                // r0 is hardwired to zero; the commit is traced but not stored.
                if (w_head.addr != 3'd0) begin
                    r_regs[w_head.addr] <= w_head.data;
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign read_data1 = (w_pop && (rd_addr1 != 3'd0) && (w_head.addr == rd_addr1))
                        ? w_head.data : r_regs[rd_addr1];
    assign read_data2 = (w_pop && (rd_addr2 != 3'd0) && (w_head.addr == rd_addr2))
                        ? w_head.data : r_regs[rd_addr2];
`else
    assign read_data1 = r_regs[rd_addr1];
    assign read_data2 = r_regs[rd_addr2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module   : tb_writeback_unit
// Brief    : Self-checking bench for writeback_unit against a queue/array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [2:0]  res_addr = '0;
    logic [7:0]  res_data = '0;
    logic        stall = 1'b0;
    logic [2:0]  rd_addr1 = '0;
    logic [2:0]  rd_addr2 = '0;
    logic [7:0]  read_data1;
    logic [7:0]  read_data2;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [15:0] commit_count;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of {addr,data}, architectural register array, trace.
    logic [10:0] m_q [$];
    logic [7:0]  m_regs [8];
    logic        m_wb_valid;
    logic [2:0]  m_wb_addr;
    logic [7:0]  m_wb_data;
    logic [15:0] m_count;

    writeback_unit u_dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_addr     (res_addr),
        .res_data     (res_data),
        .stall        (stall),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .commit_count (commit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic [7:0] v;
        v = (a == 3'd0) ? 8'h00 : m_regs[a];
`ifdef WB_BYPASS_EN
        if (m_q.size() > 0 && !stall && a != 3'd0 && m_q[0][10:8] == a) begin
            v = m_q[0][7:0];
        end
`endif
        return v;
    endfunction

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_wb_valid = 1'b0;
        m_wb_addr  = 3'd0;
        m_wb_data  = 8'h00;
        m_count    = 16'd0;
    endtask

    // One clock: drive at negedge, check combinational outputs, step model, check registered.
    task automatic cycle(input logic v, input logic [2:0] a, input logic [7:0] d,
                         input logic s, input logic [2:0] r1, input logic [2:0] r2,
                         output logic accepted);
        logic will_pop;
        logic will_push;
        @(negedge clk);
        res_valid = v;
        res_addr  = a;
        res_data  = d;
        stall     = s;
        rd_addr1  = r1;
        rd_addr2  = r2;
        #1;
        check("res_ready", 16'(res_ready), 16'(m_q.size() < 2));
        check("read_data1", 16'(read_data1), 16'(model_read(r1)));
        check("read_data2", 16'(read_data2), 16'(model_read(r2)));
        will_pop  = (m_q.size() > 0) && !s;
        will_push = v && (m_q.size() < 2);
        accepted  = will_push;
        @(posedge clk);
        #1;
        m_wb_valid = will_pop;
        if (will_pop) begin
            m_wb_addr = m_q[0][10:8];
            m_wb_data = m_q[0][7:0];
            m_count   = m_count + 16'd1;
            if (m_wb_addr != 3'd0) m_regs[m_wb_addr] = m_wb_data;
            void'(m_q.pop_front());
        end
        if (will_push) m_q.push_back({a, d});
        check("wb_valid", 16'(wb_valid), 16'(m_wb_valid));
        check("wb_addr", 16'(wb_addr), 16'(m_wb_addr));
        check("wb_data", 16'(wb_data), 16'(m_wb_data));
        check("commit_count", commit_count, m_count);
    endtask

    task automatic do_reset(input logic v, input logic s);
        @(negedge clk);
        reset     = 1'b1;
        res_valid = v;
        res_addr  = 3'd1;
        res_data  = 8'hEE;
        stall     = s;
        @(posedge clk);
        #1;
        model_clear();
        check("rst_wb_valid", 16'(wb_valid), 16'd0);
        check("rst_wb_addr", 16'(wb_addr), 16'd0);
        check("rst_wb_data", 16'(wb_data), 16'd0);
        check("rst_count", commit_count, 16'd0);
        check("rst_ready", 16'(res_ready), 16'd1);
        reset = 1'b0;
    endtask

    initial begin
        logic acc;
        logic       p_valid;
        logic [2:0] p_addr;
        logic [7:0] p_data;

        model_clear();
        do_reset(1'b0, 1'b0);

        // Reset contents: every register reads zero on both ports.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'(i), 3'(7 - i), acc);
            check("init_rd1", 16'(read_data1), 16'h0000);
        end

        // Single push to r3, then observe latency of commit and read visibility.
        cycle(1'b1, 3'd3, 8'h5A, 1'b0, 3'd3, 3'd0, acc);
        check("r3_accept", 16'(acc), 16'd1);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd3, acc);
        check("r3_wb_valid", 16'(wb_valid), 16'd1);
        check("r3_wb_addr", 16'(wb_addr), 16'd3);
        check("r3_wb_data", 16'(wb_data), 16'h5A);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd0, acc);
        check("r3_visible", 16'(read_data1), 16'h5A);
        check("r3_pulse_end", 16'(wb_valid), 16'd0);

        // Backpressure: three results under stall, third held until space frees.
        cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 3'd2, acc);
        cycle(1'b1, 3'd2, 8'h22, 1'b1, 3'd1, 3'd2, acc);
        cycle(1'b1, 3'd4, 8'h44, 1'b1, 3'd1, 3'd2, acc);
        check("bp_third_held", 16'(acc), 16'd0);
        check("bp_ready_low", 16'(res_ready), 16'd0);
        cycle(1'b1, 3'd4, 8'h44, 1'b0, 3'd1, 3'd4, acc);
        check("bp_pop_no_ready", 16'(acc), 16'd0);
        cycle(1'b1, 3'd4, 8'h44, 1'b0, 3'd1, 3'd4, acc);
        check("bp_third_accept", 16'(acc), 16'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd4, acc);
        check("bp_count", commit_count, 16'd4);
        check("bp_r4", 16'(read_data2), 16'h44);

        // Commit to r0 is traced and counted but never stored.
        cycle(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd0, acc);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, acc);
        check("r0_wb_valid", 16'(wb_valid), 16'd1);
        check("r0_wb_data", 16'(wb_data), 16'hFF);
        check("r0_count", commit_count, 16'd5);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, acc);
        check("r0_reads_zero", 16'(read_data2), 16'h0000);

        // Reset discards two queued entries, overriding a push in the same edge.
        cycle(1'b1, 3'd1, 8'hA1, 1'b1, 3'd1, 3'd1, acc);
        cycle(1'b1, 3'd1, 8'hA2, 1'b1, 3'd1, 3'd1, acc);
        do_reset(1'b1, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd1, acc);
        check("rstq_no_commit", 16'(wb_valid), 16'd0);
        check("rstq_r1", 16'(read_data1), 16'h0000);
        check("rstq_empty", 16'(res_ready), 16'd1);

        // Randomized traffic; an unaccepted result is held stable.
        p_valid = 1'b0;
        p_addr  = 3'd0;
        p_data  = 8'h00;
        acc     = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (!(p_valid && !acc)) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_addr  = 3'($urandom_range(0, 7));
                p_data  = 8'($urandom);
            end
            cycle(p_valid, p_addr, p_data, ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), acc);
        end

        // Counter wrap: 65536 commits after reset return the count to zero.
        do_reset(1'b0, 1'b0);
        for (int n = 0; n < 65536; n++) begin
            cycle(1'b1, 3'(n % 8), 8'(n), 1'b0, 3'(n % 8), 3'd5, acc);
        end
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd2, acc);
        check("wrap_count", commit_count, 16'h0000);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd2, acc);
        check("wrap_idle", 16'(wb_valid), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
